tcm_mem: RTL and testbench

TCM_MEM -- requirements
Module: tcm_mem

---
 rtl/tcm_mem.sv | 121 ++++++++++++
 tb/tb_tcm_mem.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tcm_mem.sv
// rtl/tcm_mem.sv - 128 KiB tightly-coupled memory, one-cycle fetch and data ports (option: TCM_MEM_RANGE_CHECK_EN)
module tcm_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    logic [63:0] ram [0:16383];

    logic [13:0] i_idx;
    logic [13:0] d_idx;
    logic        d_req;
    logic        i_range_err;
    logic        d_range_err;
    logic        d_wr_en;
    logic [31:0] strb_mask;
    logic [63:0] wr_mask;
    logic [63:0] wr_data;

    logic [63:0] i_word_q;
    logic [63:0] d_word_q;
    logic        i_valid_q;
    logic        i_err_q;
    logic        d_ack_q;
    logic        d_err_q;
    logic        d_rd_q;
    logic        d_hi_q;
    logic [10:0] d_tag_q;

    assign i_idx = mem_i_pc_i[16:3];
    assign d_idx = mem_d_addr_i[16:3];
    assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                 | mem_d_writeback_i | mem_d_flush_i;

`ifdef TCM_MEM_RANGE_CHECK_EN
    assign i_range_err = (mem_i_pc_i[31:17] != 15'h4000);
    assign d_range_err = (mem_d_addr_i[31:17] != 15'h4000);
`else
    assign i_range_err = 1'b0;
    assign d_range_err = 1'b0;
`endif

    // Writes are gated by rst here because the array itself has no reset.
    assign d_wr_en   = rst & (|mem_d_wr_i) & ~d_range_err;
    assign strb_mask = {{8{mem_d_wr_i[3]}}, {8{mem_d_wr_i[2]}},
                        {8{mem_d_wr_i[1]}}, {8{mem_d_wr_i[0]}}};
    assign wr_mask   = mem_d_addr_i[2] ? {strb_mask, 32'h0} : {32'h0, strb_mask};
    assign wr_data   = {mem_d_data_wr_i, mem_d_data_wr_i};

    // Reads sample the array before this edge's write lands: read-before-write.
    always @(posedge clk) begin
        i_word_q <= ram[i_idx];
        d_word_q <= ram[d_idx];
        if (d_wr_en)
            ram[d_idx] <= (ram[d_idx] & ~wr_mask) | (wr_data & wr_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rd_q    <= 1'b0;
            d_hi_q    <= 1'b0;
            d_tag_q   <= 11'h0;
        end else begin
            i_valid_q <= mem_i_rd_i;
            i_err_q   <= mem_i_rd_i & i_range_err;
            d_ack_q   <= d_req;
            d_err_q   <= d_req & d_range_err;
            d_rd_q    <= mem_d_rd_i;
            d_hi_q    <= mem_d_addr_i[2];
            if (d_req)
                d_tag_q <= mem_d_req_tag_i;
        end
    end

    assign mem_i_accept_o   = 1'b1;
    assign mem_d_accept_o   = 1'b1;
    assign mem_i_valid_o    = i_valid_q;
    assign mem_i_error_o    = i_err_q;
    assign mem_i_inst_o     = (i_valid_q & ~i_err_q) ? i_word_q : 64'h0;
    assign mem_d_ack_o      = d_ack_q;
    assign mem_d_error_o    = d_err_q;
    assign mem_d_resp_tag_o = d_tag_q;
    assign mem_d_data_rd_o  = (d_ack_q & d_rd_q & ~d_err_q)
                            ? (d_hi_q ? d_word_q[63:32] : d_word_q[31:0]) : 32'h0;

    logic unused_inputs;
    assign unused_inputs = ^{mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i[31:17],
                             mem_i_pc_i[2:0], mem_d_addr_i[31:17], mem_d_addr_i[1:0],
                             mem_d_cacheable_i};

    // Image preload backdoor; simulation use only.
    task automatic write(input logic [31:0] addr, input logic [7:0] data);
        ram[addr[16:3]][{addr[2:0], 3'b000} +: 8] <= data;
    endtask

endmodule

// File: tb/tb_tcm_mem.sv
// tb/tb_tcm_mem.sv - directed self-checking bench for tcm_mem
module tb_tcm_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    int tests = 0;
    int fails = 0;

    tcm_mem dut (
        .clk(clk), .rst(rst),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
        .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
        .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
        .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0; mem_i_pc_i = 0;
        mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
        mem_d_cacheable_i = 0; mem_d_req_tag_i = 0;
        mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;
    endtask

    task automatic dreq(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic rd, input logic [10:0] tag);
        mem_d_addr_i = a; mem_d_data_wr_i = wd; mem_d_wr_i = st;
        mem_d_rd_i = rd; mem_d_req_tag_i = tag;
    endtask

    // Inputs are set at a negedge; one edge later the response is sampled at the next negedge.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_i_valid", mem_i_valid_o, 0);
        check("rst_d_ack", mem_d_ack_o, 0);
        check("rst_i_err", mem_i_error_o, 0);
        check("rst_d_err", mem_d_error_o, 0);
        check("rst_tag", mem_d_resp_tag_o, 0);
        check("rst_inst", mem_i_inst_o, 0);
        check("rst_data", mem_d_data_rd_o, 0);
        check("accepts", {mem_i_accept_o, mem_d_accept_o}, 2'b11);

        dut.write(32'h0, 8'h13); dut.write(32'h1, 8'h00);
        dut.write(32'h2, 8'h00); dut.write(32'h3, 8'h00);
        dut.write(32'h8, 8'hEF); dut.write(32'h9, 8'hBE);
        dut.write(32'hA, 8'hAD); dut.write(32'hB, 8'hDE);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
        step();
        check("fetch_valid", mem_i_valid_o, 1);
        check("fetch_inst", mem_i_inst_o[31:0], 32'h0000_0013);
        check("fetch_err", mem_i_error_o, 0);
        step();
        check("idle_valid", mem_i_valid_o, 0);
        check("idle_ack", mem_d_ack_o, 0);

        dreq(32'h8000_9000, 32'd120, 4'hF, 0, 11'd5);
        step();
        check("st_ack", mem_d_ack_o, 1);
        check("st_tag", mem_d_resp_tag_o, 5);
        check("st_err", mem_d_error_o, 0);
        step();
        check("st_ack_once", mem_d_ack_o, 0);
        dreq(32'h8000_9000, 0, 4'h0, 1, 11'd6);
        step();
        check("ld_ack", mem_d_ack_o, 1);
        check("ld_tag", mem_d_resp_tag_o, 6);
        check("ld_data", mem_d_data_rd_o, 120);
        check("ld_word", dut.ram[14'h1200][31:0], 120);

        dreq(32'h8000_9004, 32'hAABB_CCDD, 4'hF, 0, 11'd1);
        step();
        dreq(32'h8000_9004, 32'h0000_1100, 4'b0010, 0, 11'd2);
        step();
        dreq(32'h8000_9004, 0, 4'h0, 1, 11'd3);
        step();
        check("byte_hi", mem_d_data_rd_o, 32'hAABB_11DD);
        dreq(32'h8000_9000, 0, 4'h0, 1, 11'd4);
        step();
        check("byte_lo_kept", mem_d_data_rd_o, 120);

        dreq(32'h8000_9000, 32'h55, 4'hF, 1, 11'h2AA);
        step();
        check("rw_ack", mem_d_ack_o, 1);
        check("rw_tag", mem_d_resp_tag_o, 11'h2AA);
        check("rw_old", mem_d_data_rd_o, 120);
        dreq(32'h8000_9000, 0, 4'h0, 1, 11'd0);
        step();
        check("rw_new", mem_d_data_rd_o, 32'h55);

        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0008;
        dreq(32'h8000_0008, 32'h1234_5678, 4'hF, 0, 11'd9);
        step();
        check("fw_old", mem_i_inst_o[31:0], 32'hDEAD_BEEF);
        check("fw_ack", mem_d_ack_o, 1);
        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
        @(negedge clk);
        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_000C;
        check("b2b_0", mem_i_inst_o[31:0], 32'h13);
        step();
        check("b2b_1", mem_i_inst_o[31:0], 32'h1234_5678);
        check("b2b_valid", mem_i_valid_o, 1);

        mem_d_flush_i = 1; mem_d_req_tag_i = 11'h7FF; mem_d_addr_i = 32'h8000_9000;
        step();
        check("mnt_ack", mem_d_ack_o, 1);
        check("mnt_tag", mem_d_resp_tag_o, 11'h7FF);
        check("mnt_data", mem_d_data_rd_o, 0);
        check("mnt_word", dut.ram[14'h1200][31:0], 32'h55);

        dreq(32'h8000_9000, 0, 4'h0, 1, 11'd7);
        @(posedge clk);
        #1 rst = 0;
        idle();
        #1 check("rstp_ack", mem_d_ack_o, 0);
        check("rstp_tag", mem_d_resp_tag_o, 0);
        dreq(32'h8000_9000, 32'hFFFF_FFFF, 4'hF, 0, 11'd8);
        @(negedge clk);
        @(negedge clk);
        idle();
        rst = 1;
        step();
        check("rstp_no_ack", mem_d_ack_o, 0);
        check("rstp_no_valid", mem_i_valid_o, 0);
        dreq(32'h8000_9000, 0, 4'h0, 1, 11'd10);
        step();
        check("rstp_intact", mem_d_data_rd_o, 32'h55);

        dreq(32'h0000_1000, 32'hCAFE_F00D, 4'hF, 0, 11'd11);
        step();
        check("rng_ack", mem_d_ack_o, 1);
`ifdef TCM_MEM_RANGE_CHECK_EN
        check("rng_err", mem_d_error_o, 1);
        check("rng_word", dut.ram[14'h0200][31:0], 0);
`else
        check("rng_err", mem_d_error_o, 0);
        check("rng_word", dut.ram[14'h0200][31:0], 32'hCAFE_F00D);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
